// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : regfile_write_arbiter_if
// Purpose  : Producer, probe and register-file write-port bundle for the
//            writeback arbiter.
// Revision : 1.0 - initial release
// =============================================================================
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic [ADDR_W-1:0] probe_addr;
    logic              probe_hit;

    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] write_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output probe_addr,
        input  alu_ready, mem_ready, probe_hit,
        input  we3, wa3, write_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  probe_addr,
        output alu_ready, mem_ready, probe_hit,
        output we3, wa3, write_data
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Serialises ALU and queued load writebacks onto one register-file
//            write port, keeping per-register program order.
// Revision : 1.0 - initial release
// =============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] C_FULL       = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [STV_W-1:0] C_STARVE_MAX = STV_W'(STARVE_MAX);

    // Load queue storage; occupancy is tracked separately in q_vld_q.
    logic [ADDR_W-1:0] q_addr_q [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];

    logic [DEPTH-1:0]  q_vld_q,   q_vld_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [STV_W-1:0]  starve_q,  starve_d;
    logic              we3_q,     we3_d;
    logic [ADDR_W-1:0] wa3_q,     wa3_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;

    logic [DEPTH-1:0]  alu_match;
    logic [DEPTH-1:0]  probe_match;
    logic              empty;
    logic              full;
    logic              conflict;
    logic              force_load;
    logic              alu_take;
    logic              deq;
    logic              enq;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign alu_match[i]   = q_vld_q[i] && (q_addr_q[i] == bus.alu_addr);
        assign probe_match[i] = q_vld_q[i] && (q_addr_q[i] == bus.probe_addr);
    end

    assign empty      = (count_q == '0);
    assign full       = (count_q == C_FULL);
    assign conflict   = (bus.alu_addr != '0) && (|alu_match);
    assign force_load = !empty && (conflict || (starve_q == C_STARVE_MAX));
    assign alu_take   = bus.alu_valid && !force_load;
    assign deq        = !alu_take && !empty;
    // Loads to r0 complete the handshake but are never stored.
    assign enq        = bus.mem_valid && !full && (bus.mem_addr != '0);

    assign bus.alu_ready  = !force_load;
    assign bus.mem_ready  = !full;
    assign bus.probe_hit  = (bus.probe_addr != '0) &&
                            ((|probe_match) || (we3_q && (wa3_q == bus.probe_addr)));
    assign bus.we3        = we3_q;
    assign bus.wa3        = wa3_q;
    assign bus.write_data = wdata_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        q_vld_d  = q_vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        we3_d    = 1'b0;
        wa3_d    = wa3_q;
        wdata_d  = wdata_q;

        if (alu_take) begin
            we3_d   = (bus.alu_addr != '0);
            wa3_d   = bus.alu_addr;
            wdata_d = bus.alu_data;
        end else if (deq) begin
            we3_d   = (q_addr_q[rd_ptr_q] != '0);
            wa3_d   = q_addr_q[rd_ptr_q];
            wdata_d = q_data_q[rd_ptr_q];
        end

        if (deq) begin
            q_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        // Enqueue and dequeue slots never coincide: that needs empty or full.
        if (enq) begin
            q_vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (empty || deq) begin
            starve_d = '0;
        end else if (starve_q != C_STARVE_MAX) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_vld_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wdata_q  <= '0;
        end else begin
            q_vld_q  <= q_vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wdata_q  <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr_q[wr_ptr_q] <= bus.mem_addr;
            q_data_q[wr_ptr_q] <= bus.mem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// Testbench for regfile_write_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference model every cycle.
module tb_regfile_write_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_write_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Reference model state
    logic [ADDR_W-1:0] mq_addr [$];
    logic [DATA_W-1:0] mq_data [$];
    int                m_starve;
    bit                m_we;
    logic [ADDR_W-1:0] m_wa;
    logic [DATA_W-1:0] m_wd;

    // Writes seen at the register-file port
    logic [ADDR_W-1:0] obs_wa [$];
    logic [DATA_W-1:0] obs_wd [$];

    int vectors     = 0;
    int miscompares = 0;

    function automatic bit model_holds(input logic [ADDR_W-1:0] a);
        foreach (mq_addr[i]) if (mq_addr[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_alu_ready();
        bit conflict;
        conflict = (bus.alu_addr != 0) && model_holds(bus.alu_addr);
        return !((mq_addr.size() != 0) && (conflict || m_starve == STARVE_MAX));
    endfunction

    function automatic bit exp_mem_ready();
        return mq_addr.size() != DEPTH;
    endfunction

    function automatic bit exp_probe_hit();
        return (bus.probe_addr != 0) &&
               (model_holds(bus.probe_addr) || (m_we && m_wa == bus.probe_addr));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_addr.delete();
        mq_data.delete();
        m_starve = 0;
        m_we     = 1'b0;
        m_wa     = '0;
        m_wd     = '0;
    endtask

    task automatic drive(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                         input logic [ADDR_W-1:0] pa);
        bus.alu_valid  = av;
        bus.alu_addr   = aa;
        bus.alu_data   = ad;
        bus.mem_valid  = mv;
        bus.mem_addr   = ma;
        bus.mem_data   = md;
        bus.probe_addr = pa;
    endtask

    // One clock: check combinational outputs, cross the edge, update the model,
    // then check the registered write port. Entered and left at edge+1.
    task automatic cycle();
        bit                ra, rm, av, mv;
        logic [ADDR_W-1:0] aa, ma;
        logic [DATA_W-1:0] ad, md;
        int                sz;
        bit                popped;
        #3;
        chk("alu_ready", bus.alu_ready, exp_alu_ready());
        chk("mem_ready", bus.mem_ready, exp_mem_ready());
        chk("probe_hit", bus.probe_hit, exp_probe_hit());
        ra = exp_alu_ready();
        rm = exp_mem_ready();
        av = bus.alu_valid; aa = bus.alu_addr; ad = bus.alu_data;
        mv = bus.mem_valid; ma = bus.mem_addr; md = bus.mem_data;
        @(posedge clk);
        sz     = mq_addr.size();
        popped = 1'b0;
        if (av && ra) begin
            m_we = (aa != 0);
            m_wa = aa;
            m_wd = ad;
        end else if (sz > 0) begin
            m_wa   = mq_addr.pop_front();
            m_wd   = mq_data.pop_front();
            m_we   = 1'b1;
            popped = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (sz == 0 || popped) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
        if (mv && rm && ma != 0) begin
            mq_addr.push_back(ma);
            mq_data.push_back(md);
        end
        #1;
        chk("we3", bus.we3, m_we);
        if (m_we) begin
            chk("wa3", bus.wa3, m_wa);
            chk("write_data", bus.write_data, m_wd);
        end
        if (bus.we3) begin
            obs_wa.push_back(bus.wa3);
            obs_wd.push_back(bus.write_data);
        end
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (n) cycle();
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_we3", bus.we3, 0);
        chk("rst_wa3", bus.wa3, 0);
        chk("rst_write_data", bus.write_data, 0);
        chk("rst_alu_ready", bus.alu_ready, 1);
        chk("rst_mem_ready", bus.mem_ready, 1);
        chk("rst_probe_hit", bus.probe_hit, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        obs_wa.delete();
        obs_wd.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] loads [$];
        logic [DATA_W-1:0] r7w   [$];

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        chk("init_we3", bus.we3, 0);
        chk("init_alu_ready", bus.alu_ready, 1);
        chk("init_mem_ready", bus.mem_ready, 1);

        // ALU-only write to r5
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5);
        cycle();
        chk("alu_we3", bus.we3, 1);
        chk("alu_wa3", bus.wa3, 5);
        chk("alu_data", bus.write_data, 32'hDEADBEEF);
        chk("alu_probe", bus.probe_hit, 1);

        // Async reset while a write is on the port
        pulse_reset();

        // r0 writes are dropped
        drive(1, 0, 32'h1234, 0, 0, 0, 0);
        #1 chk("r0_alu_ready", bus.alu_ready, 1);
        cycle();
        chk("r0_alu_we3", bus.we3, 0);
        drive(0, 0, 0, 1, 0, 32'h77, 0);
        #1 chk("r0_mem_ready", bus.mem_ready, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("r0_load_we3", bus.we3, 0);

        // Fill queue while ALU streams to r9; r1 is forced at starve limit
        for (int i = 1; i <= 4; i++) begin
            drive(1, 9, i, 1, ADDR_W'(i), 32'h100 + i, 0);
            cycle();
        end
        drive(1, 9, 32'h55, 0, 0, 0, 0);
        #1;
        chk("full_mem_ready", bus.mem_ready, 0);
        chk("force_alu_ready", bus.alu_ready, 0);
        obs_wa.delete();
        obs_wd.delete();
        cycle();
        chk("forced_wa3", bus.wa3, 1);
        chk("forced_data", bus.write_data, 32'h101);
        #1 chk("force_one_cycle", bus.alu_ready, 1);
        repeat (16) cycle();
        idle(3);
        foreach (obs_wa[k]) if (obs_wa[k] != 9) loads.push_back(obs_wa[k]);
        chk("drain_count", loads.size(), 4);
        for (int k = 0; k < 4; k++) begin
            logic [ADDR_W-1:0] got;
            got = (k < loads.size()) ? loads[k] : '0;
            chk("drain_order", got, k + 1);
        end

        // Conflict on r7
        obs_wa.delete();
        obs_wd.delete();
        drive(0, 0, 0, 1, 7, 32'hA, 7);
        cycle();
        drive(1, 7, 32'hB, 0, 0, 0, 7);
        #1;
        chk("conflict_alu_ready", bus.alu_ready, 0);
        chk("conflict_probe_q", bus.probe_hit, 1);
        cycle();
        #1;
        chk("conflict_released", bus.alu_ready, 1);
        chk("conflict_probe_wr", bus.probe_hit, 1);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 7);
        #1 chk("conflict_probe_b", bus.probe_hit, 1);
        cycle();
        #1 chk("conflict_probe_clear", bus.probe_hit, 0);
        foreach (obs_wa[k]) if (obs_wa[k] == 7) r7w.push_back(obs_wd[k]);
        chk("r7_write_count", r7w.size(), 2);
        chk("r7_first", (r7w.size() > 0) ? r7w[0] : 32'h0, 32'hA);
        chk("r7_second", (r7w.size() > 1) ? r7w[1] : 32'h0, 32'hB);

        // Reset with three loads pending
        for (int i = 1; i <= 3; i++) begin
            drive(1, 9, 32'h900 + i, 1, ADDR_W'(i), 32'h200 + i, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        #1 chk("pre_reset_probe", bus.probe_hit, 1);
        pulse_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (4) cycle();
        chk("post_reset_writes", obs_wa.size(), 0);

        // Random traffic over a small address range to provoke conflicts
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                drive($urandom_range(0, 1), ADDR_W'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 2) != 0, ADDR_W'($urandom_range(0, 7)), $urandom,
                      ADDR_W'($urandom_range(0, 7)));
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
